// File: rtl/config_pkg.sv
// Shared geometry, opcode/state encodings and address helper for the config tile buffer.
// The address helper is also used by the config video renderer's read side.
package config_pkg;

    localparam int unsigned BUF_COLS = 40;
    localparam int unsigned BUF_ROWS = 23;
    localparam int unsigned BUF_SIZE = 920;

    localparam logic [9:0] LAST_ADDR = 10'd919;
    localparam logic [5:0] LAST_COL  = 6'd39;
    localparam logic [5:0] LAST_CHAR = 6'd63;
    localparam logic [4:0] ROW_LIMIT = 5'd23;
    localparam logic [5:0] COL_LIMIT = 6'd40;

    typedef enum logic [1:0] {
        OP_CLEAR    = 2'd0,
        OP_PUT      = 2'd1,
        OP_FILL_ROW = 2'd2,
        OP_STRING   = 2'd3
    } cfg_op_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_PUT       = 3'd2,
        ST_FILL      = 3'd3,
        ST_STR_FETCH = 3'd4,
        ST_STR_WRITE = 3'd5,
        ST_DONE      = 3'd6
    } cfg_state_t;

    // row*40 as (row<<5)+(row<<3); the largest result (919) fits in 10 bits.
    function automatic logic [9:0] cfg_buf_addr(input logic [4:0] row, input logic [5:0] col);
        logic [9:0] row_w;
        row_w = {5'd0, row};
        return (row_w << 5) + (row_w << 3) + {4'd0, col};
    endfunction

endpackage

// File: rtl/config_tile_writer.sv
// Command-driven writer for the 40x23 config-menu tile buffer: clear, put, fill row,
// and copy zero-terminated strings from the string ROM, one write per cycle.
module config_tile_writer
    import config_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic [1:0]  cmd_op_in,
    input  logic [4:0]  cmd_row_in,
    input  logic [5:0]  cmd_col_in,
    input  logic [7:0]  cmd_arg_in,
    output logic [11:0] str_addr_out,
    input  logic [7:0]  str_data_in,
    output logic [9:0]  buf_write_addr_out,
    output logic [7:0]  buf_write_data_out,
    output logic        buf_write_en_out,
    output logic        done_out
);

    cfg_state_t state_r;
    cfg_state_t state_s;
    cfg_op_t    op_r;
    cfg_op_t    cmd_op_s;
    logic [4:0] row_r;
    logic [5:0] col_r;
    logic [7:0] arg_r;
    logic [9:0] clr_addr_r;
    logic [5:0] char_idx_r;
    logic       accept_s;
    logic       range_bad_s;
    logic       str_term_s;
    logic       str_last_s;

    assign cmd_op_s    = cfg_op_t'(cmd_op_in);
    assign accept_s    = cmd_valid_in && (state_r == ST_IDLE);
    assign range_bad_s = (cmd_row_in >= ROW_LIMIT) ||
                         (((cmd_op_s == OP_PUT) || (cmd_op_s == OP_STRING)) && (cmd_col_in >= COL_LIMIT));
    assign str_term_s  = (str_data_in == 8'h00);
    // Strings clip at the right edge rather than wrapping onto the next row.
    assign str_last_s  = (col_r == LAST_COL) || (char_idx_r == LAST_CHAR);

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command latch and per-command counters.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            op_r       <= OP_CLEAR;
            row_r      <= 5'd0;
            col_r      <= 6'd0;
            arg_r      <= 8'd0;
            clr_addr_r <= 10'd0;
            char_idx_r <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r       <= cmd_op_s;
                        row_r      <= cmd_row_in;
                        col_r      <= (cmd_op_s == OP_FILL_ROW) ? 6'd0 : cmd_col_in;
                        arg_r      <= cmd_arg_in;
                        clr_addr_r <= 10'd0;
                        char_idx_r <= 6'd0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr_r != LAST_ADDR) begin
                        clr_addr_r <= clr_addr_r + 10'd1;
                    end
                end
                ST_FILL: begin
                    if (col_r != LAST_COL) begin
                        col_r <= col_r + 6'd1;
                    end
                end
                ST_STR_WRITE: begin
                    if (!str_term_s && !str_last_s) begin
                        col_r      <= col_r + 6'd1;
                        char_idx_r <= char_idx_r + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_s = ST_IDLE;
                end else if (range_bad_s) begin
                    state_s = ST_DONE;
                end else begin
                    case (cmd_op_s)
                        OP_CLEAR:    state_s = ST_CLEAR;
                        OP_PUT:      state_s = ST_PUT;
                        OP_FILL_ROW: state_s = ST_FILL;
                        OP_STRING:   state_s = ST_STR_FETCH;
                        default:     state_s = ST_DONE;
                    endcase
                end
            end
            ST_CLEAR: begin
                if (clr_addr_r == LAST_ADDR) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_PUT: state_s = ST_DONE;
            ST_FILL: begin
                if (col_r == LAST_COL) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_STR_FETCH: state_s = ST_STR_WRITE;
            ST_STR_WRITE: begin
                if (str_term_s || str_last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_STR_FETCH;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state and command registers; address/data follow the
    // latched opcode so they stay at their last values while idle.
    always_comb begin
        cmd_ready_out      = (state_r == ST_IDLE);
        done_out           = (state_r == ST_DONE);
        str_addr_out       = {arg_r[5:0], char_idx_r};
        buf_write_en_out   = 1'b0;
        buf_write_addr_out = cfg_buf_addr(row_r, col_r);
        buf_write_data_out = arg_r;
        case (op_r)
            OP_CLEAR: begin
                buf_write_addr_out = clr_addr_r;
                buf_write_data_out = 8'h00;
            end
            OP_STRING: buf_write_data_out = str_data_in;
            default: begin
            end
        endcase
        case (state_r)
            ST_CLEAR:     buf_write_en_out = 1'b1;
            ST_PUT:       buf_write_en_out = 1'b1;
            ST_FILL:      buf_write_en_out = 1'b1;
            ST_STR_WRITE: buf_write_en_out = !str_term_s;
            default:      buf_write_en_out = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_config_tile_writer.sv
// Directed bench for config_tile_writer: logs every buffer write and done pulse with its
// cycle number, then compares against hand-computed addresses, data and timing.
module tb_config_tile_writer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        cmd_valid_in = 1'b0;
    logic        cmd_ready_out;
    logic [1:0]  cmd_op_in = 2'd0;
    logic [4:0]  cmd_row_in = 5'd0;
    logic [5:0]  cmd_col_in = 6'd0;
    logic [7:0]  cmd_arg_in = 8'd0;
    logic [11:0] str_addr_out;
    logic [7:0]  str_data_in = 8'd0;
    logic [9:0]  buf_write_addr_out;
    logic [7:0]  buf_write_data_out;
    logic        buf_write_en_out;
    logic        done_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];
    int dq_cyc[$];
    logic [7:0] rom [0:4095];

    config_tile_writer dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .cmd_op_in(cmd_op_in), .cmd_row_in(cmd_row_in),
        .cmd_col_in(cmd_col_in), .cmd_arg_in(cmd_arg_in),
        .str_addr_out(str_addr_out), .str_data_in(str_data_in),
        .buf_write_addr_out(buf_write_addr_out), .buf_write_data_out(buf_write_data_out),
        .buf_write_en_out(buf_write_en_out), .done_out(done_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // String ROM: one-cycle read latency.
    always @(posedge clk_in) str_data_in <= rom[str_addr_out];

    always @(negedge clk_in) begin
        if (buf_write_en_out) begin
            wq_addr.push_back(int'(buf_write_addr_out));
            wq_data.push_back(int'(buf_write_data_out));
            wq_cyc.push_back(cyc);
        end
        if (done_out) dq_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearq();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        dq_cyc.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with acc = that cycle.
    task automatic send(input logic [1:0] op, input logic [4:0] row, input logic [5:0] col,
                        input logic [7:0] arg, output int acc);
        logic rdy;
        cmd_op_in = op;
        cmd_row_in = row;
        cmd_col_in = col;
        cmd_arg_in = arg;
        cmd_valid_in = 1'b1;
        acc = -1;
        for (int i = 0; i < 3000; i++) begin
            rdy = cmd_ready_out;
            @(posedge clk_in);
            @(negedge clk_in);
            if (rdy) begin
                acc = cyc;
                break;
            end
        end
        cmd_valid_in = 1'b0;
        chk("accept_timeout", (acc >= 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    function automatic int first(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    initial begin
        int a;
        int b;
        int bad;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[192] = 8'h41; rom[193] = 8'h42; rom[194] = 8'h43; rom[195] = 8'h00;
        rom[320] = 8'h48; rom[321] = 8'h45; rom[322] = 8'h4C; rom[323] = 8'h4C;
        rom[324] = 8'h4F; rom[325] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        chk("rst_ready", 32'(cmd_ready_out), 32'd1);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_wen", 32'(buf_write_en_out), 32'd0);
        chk("rst_waddr", 32'(buf_write_addr_out), 32'd0);
        chk("rst_wdata", 32'(buf_write_data_out), 32'd0);
        chk("rst_saddr", 32'(str_addr_out), 32'd0);

        // CLEAR: 920 zero writes on consecutive cycles, done after the last
        clearq();
        send(2'd0, 5'd0, 6'd0, 8'h55, a);
        repeat (930) @(negedge clk_in);
        #1;
        chk("clear_count", 32'(wq_addr.size()), 32'd920);
        bad = 0;
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] != i || wq_data[i] != 0 || wq_cyc[i] != a + i) bad++;
        chk("clear_seq", 32'(bad), 32'd0);
        chk("clear_done_n", 32'(dq_cyc.size()), 32'd1);
        chk("clear_done_t", 32'(first(dq_cyc)), 32'(a + 920));

        // PUT at the last cell
        clearq();
        send(2'd1, 5'd22, 6'd39, 8'h41, a);
        chk("put_busy", 32'(cmd_ready_out), 32'd0);
        @(negedge clk_in);
        chk("put_done_pulse", 32'(done_out), 32'd1);
        @(negedge clk_in);
        chk("put_ready_back", 32'(cmd_ready_out), 32'd1);
        #1;
        chk("put_count", 32'(wq_addr.size()), 32'd1);
        chk("put_addr", 32'(first(wq_addr)), 32'd919);
        chk("put_data", 32'(first(wq_data)), 32'h41);
        chk("put_wcyc", 32'(first(wq_cyc)), 32'(a));
        chk("put_done_t", 32'(first(dq_cyc)), 32'(a + 1));

        // Out-of-range row: no writes, done immediately
        clearq();
        send(2'd1, 5'd23, 6'd0, 8'h41, a);
        repeat (4) @(negedge clk_in);
        #1;
        chk("oor_count", 32'(wq_addr.size()), 32'd0);
        chk("oor_done_t", 32'(first(dq_cyc)), 32'(a));

        // STRING "ABC" at row 2 col 10
        clearq();
        send(2'd3, 5'd2, 6'd10, 8'd3, a);
        repeat (12) @(negedge clk_in);
        #1;
        chk("str_count", 32'(wq_addr.size()), 32'd3);
        bad = 0;
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] != 90 + i || wq_data[i] != 8'h41 + i || wq_cyc[i] != a + 1 + 2 * i) bad++;
        chk("str_seq", 32'(bad), 32'd0);
        chk("str_done_t", 32'(first(dq_cyc)), 32'(a + 8));

        // STRING "HELLO" at col 38 clips after col 39
        clearq();
        send(2'd3, 5'd0, 6'd38, 8'd5, a);
        repeat (12) @(negedge clk_in);
        #1;
        chk("clip_count", 32'(wq_addr.size()), 32'd2);
        chk("clip_addr0", 32'(first(wq_addr)), 32'd38);
        chk("clip_data0", 32'(first(wq_data)), 32'h48);
        chk("clip_addr1", (wq_addr.size() > 1) ? 32'(wq_addr[1]) : 32'hFFFF, 32'd39);
        chk("clip_data1", (wq_data.size() > 1) ? 32'(wq_data[1]) : 32'hFFFF, 32'h45);
        chk("clip_done_t", 32'(first(dq_cyc)), 32'(a + 4));

        // FILL_ROW row 1 with a PUT held pending
        clearq();
        send(2'd2, 5'd1, 6'd17, 8'h7F, a);
        send(2'd1, 5'd0, 6'd5, 8'h22, b);
        repeat (4) @(negedge clk_in);
        #1;
        chk("fill_count", 32'(wq_addr.size()), 32'd41);
        bad = 0;
        for (int i = 0; i < 40 && i < wq_addr.size(); i++)
            if (wq_addr[i] != 40 + i || wq_data[i] != 8'h7F || wq_cyc[i] != a + i) bad++;
        chk("fill_seq", 32'(bad), 32'd0);
        chk("fill_done_t", 32'(first(dq_cyc)), 32'(a + 40));
        chk("held_put_acc", 32'(b), 32'(a + 42));
        chk("held_put_addr", (wq_addr.size() > 40) ? 32'(wq_addr[40]) : 32'hFFFF, 32'd5);
        chk("held_put_data", (wq_data.size() > 40) ? 32'(wq_data[40]) : 32'hFFFF, 32'h22);
        chk("held_put_done_n", 32'(dq_cyc.size()), 32'd2);

        // Reset in the middle of CLEAR after 100 writes
        clearq();
        send(2'd0, 5'd0, 6'd0, 8'h00, a);
        #1;
        for (int i = 0; i < 2000 && wq_addr.size() < 100; i++) begin
            @(negedge clk_in);
            #1;
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("abort_ready", 32'(cmd_ready_out), 32'd1);
        chk("abort_wen", 32'(buf_write_en_out), 32'd0);
        repeat (10) @(negedge clk_in);
        #1;
        chk("abort_count", 32'(wq_addr.size()), 32'd100);
        chk("abort_no_done", 32'(dq_cyc.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_tile_writer.md
# config_tile_writer

Command-driven writer that fills the config-menu tile buffer, which the config video renderer reads every frame. Accepts one command at a time over a valid/ready handshake: clear screen, put one tile, fill one row, or copy a zero-terminated string from the string ROM. Drives the write port of the 40x23 tile-index buffer (920 entries, 10-bit address, 8-bit tile index). Sits between the menu state logic and the dual-port tile buffer BRAM.

## Interface
- No parameters. Geometry constants come from `config_pkg`.
- clk_in  input  1  system clock; one clock for the whole block.
- rst_in  input  1  reset; synchronous, active-high.
- cmd_valid_in  input  1  command present.
- cmd_ready_out  output  1  block can accept a command; high only in IDLE.
- cmd_op_in  input  2  opcode: 0 CLEAR, 1 PUT, 2 FILL_ROW, 3 STRING.
- cmd_row_in  input  5  target row, 0..22.
- cmd_col_in  input  6  target column, 0..39. Ignored by CLEAR and FILL_ROW.
- cmd_arg_in  input  8  PUT/FILL_ROW: tile index. STRING: bits [5:0] are the string id.
- str_addr_out  output  12  string ROM address, {id[5:0], char_idx[5:0]}.
- str_data_in  input  8  string ROM data. Valid one cycle after the address is driven.
- buf_write_addr_out  output  10  tile buffer address, row*40+col.
- buf_write_data_out  output  8  tile index to write.
- buf_write_en_out  output  1  write strobe.
- done_out  output  1  one-cycle pulse when a command finishes.

## Operation
- States: IDLE, CLEAR, PUT, FILL, STR_FETCH, STR_WRITE, DONE.
- A command is accepted on any edge where `cmd_valid_in && cmd_ready_out`. Row, col, arg and op are latched on that edge.
- **Range check:** if row ≥ 23, or col ≥ 40 for PUT/STRING, the command is accepted, performs no writes, and goes straight to DONE.
- **CLEAR:** writes tile 0 to addresses 0..919 in order, one per cycle, then goes to DONE.
- **PUT:** one write of arg to row*40+col, then DONE.
- **FILL_ROW:** writes arg to cols 0..39 of the row, one per cycle, then DONE.
- **STRING:** char_idx starts at 0 and the column starts at col.
  - STR_FETCH drives str_addr_out.
  - STR_WRITE samples str_data_in.
  - If the data is 0x00 (terminator), go to DONE with no write.
  - Otherwise write the data at the current row/column and advance char_idx and column.
  - Go to DONE after writing column 39 (clip, no wrap to the next row) or char_idx 63. Otherwise return to STR_FETCH.
- **DONE:** done_out=1 for one cycle, then IDLE.
- The write port outputs are combinational from the state registers. buf_write_en_out is high only in CLEAR, PUT, FILL, and in STR_WRITE with non-zero data.
- Address arithmetic: row*40 = (row<<5)+(row<<3), zero-extended to 10 bits. Maximum address is 919, so it never overflows.
- When idle: buf_write_en_out=0, and buf_write_addr_out/data_out/str_addr_out are held at their last values. Their values are don't-care to the BRAM.

## Timing
- Reset values:
  - state IDLE
  - cmd_ready_out=1 (IDLE)
  - done_out=0
  - buf_write_en_out=0
  - buf_write_addr_out=0, buf_write_data_out=0
  - str_addr_out=0
  - all counters 0
- Reset mid-command aborts immediately. There are no writes in the cycle after the reset edge, and no done pulse for the aborted command.
- With accept on edge N:
  - PUT: write in cycle N+1, done in N+2, ready again in N+3.
  - CLEAR: writes in cycles N+1..N+920, done in N+921.
  - FILL_ROW: writes in cycles N+1..N+40, done in N+41.
  - STRING: two cycles per character. First fetch in N+1, first possible write in N+2. A k-character terminated string takes 2k+2 cycles to reach DONE.
  - Out-of-range command: done in N+1.
- cmd_ready_out is low from the cycle after accept through DONE. Commands presented while busy are not consumed and must be held by the sender.
- cmd_valid_in high in DONE is accepted only after the block returns to IDLE.

## Structure
- `config_pkg` holds:
  - BUF_COLS=40, BUF_ROWS=23, BUF_SIZE=920
  - the opcode enum `cfg_op_t`
  - the state enum
  - the function `cfg_buf_addr(row, col)`, shared with the video renderer's read-address calculation.
- Single module, no sub-modules. The string ROM and tile buffer are instantiated by the parent.

## Test plan
- Reset, then CLEAR -> 920 writes of 0x00 to addresses 0..919 on consecutive cycles, and done exactly at N+921.
- PUT row=22 col=39 arg=0x41 -> one write, addr 919, data 0x41. Repeat with row=23 -> no writes, done at N+1.
- STRING id=3 where ROM[192..194]="ABC",ROM[195]=0, at row=2 col=10 -> writes 0x41@90, 0x42@91, 0x43@92, then done. STRING with col=38 and a 5-character string -> only cols 38,39 written.
- FILL_ROW row=1 arg=0x7F -> writes to addresses 40..79. cmd_valid_in held high with a PUT during the fill -> PUT accepted only after done, and its write lands after address 79.
- Assert rst_in mid-CLEAR at write 100 -> no writes after the reset edge, no done, cmd_ready_out=1 the cycle after reset.
